// File: rtl/alu_seq_ctrl.sv
// Multi-word (1-4 x 16 bit) add/or/and/not sequencer around an external combinational ALU.
// One word per cycle in RUN, a one-cycle DONE pulse follows; start and operand writes are ignored while busy.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [1:0]  nwords,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        cy_flag,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_aluc,
  output logic        alu_cy_in,
  input  logic [15:0] alu_z,
  input  logic        alu_cy_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_MADD = 2'b00;
  localparam logic [1:0] OP_MOR  = 2'b01;
  localparam logic [1:0] OP_MAND = 2'b10;
  localparam logic [1:0] OP_MNOT = 2'b11;

  localparam logic [3:0] ALUC_ADD  = 4'b0100;
  localparam logic [3:0] ALUC_ADC  = 4'b0101;
  localparam logic [3:0] ALUC_OR   = 4'b0110;
  localparam logic [3:0] ALUC_AND  = 4'b0111;
  localparam logic [3:0] ALUC_NOTA = 4'b0010;
  localparam logic [3:0] ALUC_IDLE = 4'b1000;

  state_t      state_q, state_d;
  logic [15:0] a_bank [4];
  logic [15:0] b_bank [4];
  logic [15:0] r_bank [4];
  logic [1:0]  idx;
  logic [1:0]  last;
  logic [1:0]  op_q;
  logic        cq;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= 2'd0;
      last    <= 2'd0;
      op_q    <= 2'd0;
      cq      <= 1'b0;
      cy_flag <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_bank[i] <= 16'd0;
        b_bank[i] <= 16'd0;
        r_bank[i] <= 16'd0;
      end
    end else begin
      // Operands are frozen once an operation is in flight.
      if (wr_en && state_q == IDLE) begin
        if (wr_sel) b_bank[wr_addr] <= wr_data;
        else        a_bank[wr_addr] <= wr_data;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q <= op;
            last <= nwords;
            idx  <= 2'd0;
            cq   <= 1'b0;
          end
        end
        RUN: begin
          r_bank[idx] <= alu_z;
          cq <= (op_q == OP_MADD) ? alu_cy_out : 1'b0;
          if (idx != last) idx <= idx + 2'd1;
        end
        DONE: cy_flag <= cq;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    alu_a     = 16'd0;
    alu_b     = 16'd0;
    alu_aluc  = ALUC_IDLE;
    alu_cy_in = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        alu_a = a_bank[idx];
        alu_b = b_bank[idx];
        case (op_q)
          OP_MADD: begin
            alu_aluc  = (idx == 2'd0) ? ALUC_ADD : ALUC_ADC;
            alu_cy_in = (idx == 2'd0) ? 1'b0 : cq;
          end
          OP_MOR:  alu_aluc = ALUC_OR;
          OP_MAND: alu_aluc = ALUC_AND;
          OP_MNOT: alu_aluc = ALUC_NOTA;
          default: alu_aluc = ALUC_IDLE;
        endcase
        if (idx == last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, but outputs must already look idle while it is held.
    if (!rst_n) begin
      busy      = 1'b0;
      done      = 1'b0;
      alu_a     = 16'd0;
      alu_b     = 16'd0;
      alu_aluc  = ALUC_IDLE;
      alu_cy_in = 1'b0;
    end
  end

  assign rd_data = r_bank[rd_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU, wide-integer reference model, directed plus random operations.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_en, wr_sel;
  logic [1:0]  op, nwords, wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data, alu_a, alu_b, alu_z;
  logic        busy, done, cy_flag, alu_cy_in, alu_cy_out;
  logic [3:0]  alu_aluc;

  int total = 0;
  int bad   = 0;

  logic [15:0] ma [4];
  logic [15:0] mb [4];
  logic [15:0] mr [4];
  logic        mcy;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .nwords(nwords),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .cy_flag(cy_flag), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_cy_in(alu_cy_in), .alu_z(alu_z), .alu_cy_out(alu_cy_out)
  );

  // External ALU; logic ops drive a junk carry that the sequencer must ignore.
  always_comb begin
    alu_z      = 16'd0;
    alu_cy_out = 1'b0;
    case (alu_aluc)
      4'b0100: {alu_cy_out, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0101: {alu_cy_out, alu_z} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cy_in};
      4'b0110: begin alu_z = alu_a | alu_b; alu_cy_out = 1'b1; end
      4'b0111: begin alu_z = alu_a & alu_b; alu_cy_out = 1'b1; end
      4'b0010: begin alu_z = ~alu_a;        alu_cy_out = 1'b1; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic sel, input logic [1:0] addr, input logic [15:0] data);
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
  endtask

  task automatic wr(input logic sel, input logic [1:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    model_write(sel, addr, data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_results(input string tag);
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      #1;
      chk(tag, 64'(rd_data), 64'(mr[k]));
    end
  endtask

  function automatic logic [63:0] low_mask(input int nw);
    if (nw >= 4) return '1;
    return (64'd1 << (16 * nw)) - 64'd1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic do_op(input logic [1:0] o, input logic [1:0] n, input bit hold_start,
                       input bit wr_run, input bit wr_same, input logic wsel,
                       input logic [1:0] waddr, input logic [15:0] wdat);
    logic [63:0] va, vb, vr, m;
    logic [64:0] sum, ps;
    logic [3:0]  exp_aluc;
    logic        exp_cy, exp_cin;
    int          nw;
    if (wr_same) begin
      wr_en = 1'b1; wr_sel = wsel; wr_addr = waddr; wr_data = wdat;
      model_write(wsel, waddr, wdat);
    end
    start = 1'b1; op = o; nwords = n;
    nw = int'(n) + 1;
    va = {ma[3], ma[2], ma[1], ma[0]};
    vb = {mb[3], mb[2], mb[1], mb[0]};
    m  = low_mask(nw);
    sum = {1'b0, va & m} + {1'b0, vb & m};
    exp_cy = 1'b0;
    case (o)
      2'b00: begin vr = sum[63:0] & m; exp_cy = sum[16 * nw]; end
      2'b01: vr = (va | vb) & m;
      2'b10: vr = (va & vb) & m;
      default: vr = ~va & m;
    endcase
    @(negedge clk);
    wr_en = 1'b0;
    if (!hold_start) start = 1'b0;
    for (int c = 1; c <= nw; c++) begin
      int w = c - 1;
      m  = low_mask(w);
      ps = {1'b0, va & m} + {1'b0, vb & m};
      exp_cin = (o == 2'b00 && w > 0) ? ps[16 * w] : 1'b0;
      case (o)
        2'b00:   exp_aluc = (w == 0) ? 4'b0100 : 4'b0101;
        2'b01:   exp_aluc = 4'b0110;
        2'b10:   exp_aluc = 4'b0111;
        default: exp_aluc = 4'b0010;
      endcase
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_done", 64'(done), 64'd0);
      chk("run_aluc", 64'(alu_aluc), 64'(exp_aluc));
      chk("run_cyin", 64'(alu_cy_in), 64'(exp_cin));
      chk("run_alu_a", 64'(alu_a), 64'(ma[w]));
      chk("run_alu_b", 64'(alu_b), 64'(mb[w]));
      if (wr_run) begin
        wr_en = 1'b1; wr_sel = $urandom_range(0, 1) == 1; wr_addr = 2'(w);
        wr_data = 16'($urandom);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_aluc", 64'(alu_aluc), 64'h8);
    chk("done_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);
    chk("after_done", 64'(done), 64'd0);
    chk("after_busy", 64'(busy), 64'd0);
    for (int k = 0; k < nw; k++) mr[k] = vr[16 * k +: 16];
    mcy = exp_cy;
    chk("cy_flag", 64'(cy_flag), 64'(mcy));
    check_results("result");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; nwords = 2'd0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 16'd0; rd_addr = 2'd0;
    for (int i = 0; i < 4; i++) begin ma[i] = 16'd0; mb[i] = 16'd0; mr[i] = 16'd0; end
    mcy = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aluc", 64'(alu_aluc), 64'h8);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_cy", 64'(cy_flag), 64'd0);
    check_results("rst_r");
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // 64-bit add rolling over to zero with carry out
    for (int i = 0; i < 4; i++) wr(1'b0, 2'(i), 16'hFFFF);
    wr(1'b1, 2'd0, 16'h0001);
    do_op(2'b00, 2'd3, 0, 0, 0, 1'b0, 2'd0, 16'd0);

    // 1-word OR; upper result words retained
    wr(1'b0, 2'd0, 16'h00F0);
    wr(1'b1, 2'd0, 16'h0F00);
    do_op(2'b01, 2'd0, 0, 0, 0, 1'b0, 2'd0, 16'd0);
    chk("mor_r0", 64'(mr[0]), 64'h0FF0);

    // 32-bit add with carry between words
    wr(1'b0, 2'd0, 16'h8000); wr(1'b0, 2'd1, 16'h0001);
    wr(1'b1, 2'd0, 16'h8000); wr(1'b1, 2'd1, 16'h0000);
    do_op(2'b00, 2'd1, 0, 0, 0, 1'b0, 2'd0, 16'd0);

    // start held high and writes attempted throughout a 4-word add
    do_op(2'b00, 2'd3, 1, 1, 0, 1'b0, 2'd0, 16'd0);
    do_op(2'b10, 2'd3, 0, 0, 0, 1'b0, 2'd0, 16'd0);

    // write and start in the same cycle
    do_op(2'b11, 2'd0, 0, 0, 1, 1'b0, 2'd0, 16'h1234);
    chk("mnot_r0", 64'(mr[0]), 64'hEDCB);

    for (int it = 0; it < 24; it++) begin
      int nwr = $urandom_range(0, 3);
      for (int j = 0; j < nwr; j++)
        wr($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 16'($urandom));
      do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 16'($urandom));
    end

    // make R non-zero, then abort a 4-word NOT in its second RUN cycle
    for (int i = 0; i < 4; i++) wr(1'b0, 2'(i), 16'h0F0F + 16'(i));
    do_op(2'b01, 2'd3, 0, 0, 0, 1'b0, 2'd0, 16'd0);
    start = 1'b1; op = 2'b11; nwords = 2'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy_held", 64'(busy), 64'd0);
    chk("abort_aluc_held", 64'(alu_aluc), 64'h8);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin ma[i] = 16'd0; mb[i] = 16'd0; mr[i] = 16'd0; end
    mcy = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_aluc", 64'(alu_aluc), 64'h8);
    chk("abort_cy", 64'(cy_flag), 64'd0);
    check_results("abort_r");
    for (int c = 0; c < 6; c++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    do_op(2'b00, 2'd3, 0, 0, 0, 1'b0, 2'd0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
